// File: rtl/i2c_s_if.sv
// I2C target interface: oversampled SCL/SDA in the clk domain, fixed 7-bit address,
// write bytes collected into a left-justified word, read bytes served from rd_data.
module i2c_s_if #(
  parameter logic [6:0] p_adr = 7'h50
) (
  input  logic        clk,
  input  logic        rstb,
  input  logic        scl_i,
  input  logic        sda_i,
  output logic        sda_o,
  output logic [31:0] wr_data,
  output logic [2:0]  wr_bytes,
  output logic        wr_data_en,
  output logic        rd_req,
  input  logic [31:0] rd_data,
  output logic        busy
);

  typedef enum logic [2:0] {
    S_IDLE, S_ADR, S_ADR_ACK, S_WR, S_WR_ACK, S_RD, S_RD_ACK, S_WAIT_STOP
  } state_t;

  logic [2:0]  scl_q, sda_q;
  state_t      state_q;
  logic [3:0]  bit_cnt_q;
  logic [2:0]  byte_cnt_q;
  logic [7:0]  shift_q;
  logic [31:0] acc_q;
  logic [31:0] tx_q;
  logic        mack_q;
  logic        sda_o_q;
  logic        rd_req_q;
  logic        wr_en_q;
  logic [31:0] wr_data_q;
  logic [2:0]  wr_bytes_q;

  logic scl_rise, scl_fall, start_ev, stop_ev;

  // [0],[1] synchronize; [2] is the previous sample used for edge detection
  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      scl_q <= 3'b111;
      sda_q <= 3'b111;
    end else begin
      scl_q <= {scl_q[1:0], scl_i};
      sda_q <= {sda_q[1:0], sda_i};
    end
  end

  assign scl_rise = scl_q[1] & ~scl_q[2];
  assign scl_fall = ~scl_q[1] & scl_q[2];
  assign start_ev = scl_q[1] & scl_q[2] & sda_q[2] & ~sda_q[1];
  assign stop_ev  = scl_q[1] & scl_q[2] & ~sda_q[2] & sda_q[1];

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state_q    <= S_IDLE;
      bit_cnt_q  <= '0;
      byte_cnt_q <= '0;
      shift_q    <= '0;
      acc_q      <= '0;
      tx_q       <= '1;
      mack_q     <= 1'b1;
      sda_o_q    <= 1'b1;
      rd_req_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      wr_bytes_q <= '0;
    end else begin
      rd_req_q <= 1'b0;
      wr_en_q  <= 1'b0;
      if (start_ev || stop_ev) begin
        // byte_cnt_q is only nonzero inside a write, so it alone gates the flush
        if (byte_cnt_q != 3'd0) begin
          wr_en_q    <= 1'b1;
          wr_data_q  <= acc_q;
          wr_bytes_q <= byte_cnt_q;
        end
        sda_o_q    <= 1'b1;
        bit_cnt_q  <= '0;
        byte_cnt_q <= '0;
        if (start_ev) begin
          state_q <= S_ADR;
          acc_q   <= '0;
        end else begin
          state_q <= S_IDLE;
        end
      end else begin
        case (state_q)
          S_IDLE: ;
          S_ADR, S_WR: begin
            if (scl_rise) begin
              shift_q   <= {shift_q[6:0], sda_q[1]};
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall && bit_cnt_q == 4'd8) begin
              bit_cnt_q <= '0;
              if (state_q == S_ADR) begin
                if (shift_q[7:1] == p_adr) begin
                  sda_o_q  <= 1'b0;
                  rd_req_q <= shift_q[0];
                  state_q  <= S_ADR_ACK;
                end else begin
                  state_q <= S_WAIT_STOP;
                end
              end else begin
                if (!byte_cnt_q[2]) begin
                  case (byte_cnt_q[1:0])
                    2'd0: acc_q[31:24] <= shift_q;
                    2'd1: acc_q[23:16] <= shift_q;
                    2'd2: acc_q[15:8]  <= shift_q;
                    default: acc_q[7:0] <= shift_q;
                  endcase
                  byte_cnt_q <= byte_cnt_q + 3'd1;
                  sda_o_q    <= 1'b0;
                end
                state_q <= S_WR_ACK;
              end
            end
          end
          S_ADR_ACK: begin
            if (scl_fall) begin
              bit_cnt_q <= '0;
              if (shift_q[0]) begin
                tx_q    <= rd_data;
                sda_o_q <= rd_data[31];
                state_q <= S_RD;
              end else begin
                sda_o_q <= 1'b1;
                state_q <= S_WR;
              end
            end
          end
          S_WR_ACK: begin
            if (scl_fall) begin
              sda_o_q <= 1'b1;
              state_q <= S_WR;
            end
          end
          S_RD: begin
            if (scl_rise) begin
              bit_cnt_q <= bit_cnt_q + 4'd1;
            end else if (scl_fall) begin
              // ones shift in so bytes past the fourth read as 8'hFF
              tx_q <= {tx_q[30:0], 1'b1};
              if (bit_cnt_q == 4'd8) begin
                sda_o_q <= 1'b1;
                state_q <= S_RD_ACK;
              end else begin
                sda_o_q <= tx_q[30];
              end
            end
          end
          S_RD_ACK: begin
            if (scl_rise) begin
              mack_q <= sda_q[1];
            end else if (scl_fall) begin
              bit_cnt_q <= '0;
              if (!mack_q) begin
                sda_o_q <= tx_q[31];
                state_q <= S_RD;
              end else begin
                state_q <= S_WAIT_STOP;
              end
            end
          end
          default: sda_o_q <= 1'b1;
        endcase
      end
    end
  end

  assign sda_o      = sda_o_q;
  assign rd_req     = rd_req_q;
  assign wr_data_en = wr_en_q;
  assign wr_data    = wr_data_q;
  assign wr_bytes   = wr_bytes_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_i2c_s_if.sv
// Bench for i2c_s_if: a bit-banged bus master plus a scoreboard for write flushes.
module tb_i2c_s_if;
  localparam int H = 20;

  logic        clk = 1'b0;
  logic        rstb = 1'b0;
  logic        scl = 1'b1;
  logic        sda_m = 1'b1;
  logic        sda_bus;
  logic        sda_o;
  logic [31:0] wr_data;
  logic [2:0]  wr_bytes;
  logic        wr_data_en;
  logic        rd_req;
  logic [31:0] rd_data = 32'h0;
  logic        busy;

  int n_vec = 0;
  int n_err = 0;
  int rd_req_cnt = 0;
  int cnt0;
  logic [34:0] exp_q[$];
  logic [34:0] e;

  assign sda_bus = sda_m & sda_o;

  always #5 clk = ~clk;

  i2c_s_if #(.p_adr(7'h50)) dut (
    .clk(clk), .rstb(rstb), .scl_i(scl), .sda_i(sda_bus), .sda_o(sda_o),
    .wr_data(wr_data), .wr_bytes(wr_bytes), .wr_data_en(wr_data_en),
    .rd_req(rd_req), .rd_data(rd_data), .busy(busy)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // scoreboard monitor: every wr_data_en pulse must match the oldest expectation
  always @(negedge clk) begin
    if (rd_req) rd_req_cnt++;
    if (wr_data_en) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL wr_unexpected: got pulse bytes=%0d data=%h expected no pulse", wr_bytes, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_bytes, wr_data} !== e) begin
          n_err++;
          $display("FAIL wr_flush: got bytes=%0d data=%h expected bytes=%0d data=%h",
                   wr_bytes, wr_data, e[34:32], e[31:0]);
        end
      end
    end
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
  endtask

  task automatic start_c();
    clk_n(5); sda_m = 1'b1; clk_n(H-5); scl = 1'b1;
    clk_n(H); sda_m = 1'b0; clk_n(H); scl = 1'b0;
  endtask

  task automatic stop_c();
    clk_n(5); sda_m = 1'b0; clk_n(H-5); scl = 1'b1;
    clk_n(H); sda_m = 1'b1; clk_n(H);
  endtask

  task automatic send_bits(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      clk_n(5); sda_m = b[i]; clk_n(H-5); scl = 1'b1; clk_n(H); scl = 1'b0;
    end
  endtask

  task automatic ack_slot(output logic a);
    clk_n(5); sda_m = 1'b1; clk_n(H-5); scl = 1'b1;
    clk_n(H/2); @(negedge clk); a = sda_bus; clk_n(H/2); scl = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic a;
    send_bits(b);
    ack_slot(a);
    chk(nm, {31'd0, a}, {31'd0, exp_ack});
  endtask

  task automatic recv_byte(input logic nack, input logic [7:0] exp, input string nm);
    logic [7:0] r;
    clk_n(5); sda_m = 1'b1;
    for (int i = 7; i >= 0; i--) begin
      clk_n(H); scl = 1'b1; clk_n(H/2); @(negedge clk); r[i] = sda_bus; clk_n(H/2); scl = 1'b0;
    end
    clk_n(5); sda_m = nack; clk_n(H-5); scl = 1'b1; clk_n(H); scl = 1'b0;
    chk(nm, {24'd0, r}, {24'd0, exp});
  endtask

  initial begin
    clk_n(3);
    @(negedge clk);
    chk("rst_sda_o", {31'd0, sda_o}, 32'd1);
    chk("rst_wr_data", wr_data, 32'd0);
    chk("rst_wr_bytes", {29'd0, wr_bytes}, 32'd0);
    chk("rst_pulses", {30'd0, wr_data_en, rd_req}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    rstb = 1'b1;
    clk_n(10);

    // write two bytes to own address
    start_c();
    send_byte(8'hA0, 1'b0, "t1_adr_ack");
    send_byte(8'hA5, 1'b0, "t1_d0_ack");
    send_byte(8'h3C, 1'b0, "t1_d1_ack");
    exp_q.push_back({3'd2, 32'hA53C0000});
    stop_c();
    clk_n(10);
    chk("t1_busy_after_stop", {31'd0, busy}, 32'd0);

    // foreign address: no ACKs, no flush
    start_c();
    send_byte(8'hA2, 1'b1, "t2_adr_nack");
    send_byte(8'h11, 1'b1, "t2_d0_nack");
    send_byte(8'h22, 1'b1, "t2_d1_nack");
    @(negedge clk);
    chk("t2_busy_before_stop", {31'd0, busy}, 32'd1);
    stop_c();
    clk_n(10);
    chk("t2_busy_after_stop", {31'd0, busy}, 32'd0);

    // read two bytes, NACK the second
    rd_data = 32'h12345678;
    cnt0 = rd_req_cnt;
    start_c();
    send_byte(8'hA1, 1'b0, "t3_adr_ack");
    chk("t3_rd_req_once", 32'(rd_req_cnt - cnt0), 32'd1);
    recv_byte(1'b0, 8'h12, "t3_rd0");
    recv_byte(1'b1, 8'h34, "t3_rd1");
    @(negedge clk);
    chk("t3_sda_released", {31'd0, sda_o}, 32'd1);
    stop_c();
    clk_n(10);
    chk("t3_idle_after_stop", {31'd0, busy}, 32'd0);

    // five-byte write: fifth byte NACKed and dropped
    start_c();
    send_byte(8'hA0, 1'b0, "t4_adr_ack");
    send_byte(8'h01, 1'b0, "t4_d0_ack");
    send_byte(8'h02, 1'b0, "t4_d1_ack");
    send_byte(8'h03, 1'b0, "t4_d2_ack");
    send_byte(8'h04, 1'b0, "t4_d3_ack");
    send_byte(8'h05, 1'b1, "t4_d4_nack");
    exp_q.push_back({3'd4, 32'h01020304});
    stop_c();
    clk_n(10);

    // write one byte, repeated START, read four bytes
    start_c();
    send_byte(8'hA0, 1'b0, "t5_adr_ack");
    send_byte(8'h77, 1'b0, "t5_d0_ack");
    exp_q.push_back({3'd1, 32'h77000000});
    rd_data = 32'hDEADBEEF;
    start_c();
    send_byte(8'hA1, 1'b0, "t5_rd_adr_ack");
    recv_byte(1'b0, 8'hDE, "t5_rd0");
    recv_byte(1'b0, 8'hAD, "t5_rd1");
    recv_byte(1'b0, 8'hBE, "t5_rd2");
    recv_byte(1'b1, 8'hEF, "t5_rd3");
    stop_c();
    clk_n(10);
    chk("t5_wr_data_held", wr_data, 32'h77000000);

    // reset while the address ACK is being driven
    start_c();
    send_bits(8'hA0);
    clk_n(10);
    @(negedge clk);
    chk("t6_ack_driven", {31'd0, sda_o}, 32'd0);
    rstb = 1'b0;
    #1;
    chk("t6_rst_sda_o", {31'd0, sda_o}, 32'd1);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_wr_data", wr_data, 32'd0);
    clk_n(3);
    scl = 1'b1;
    sda_m = 1'b1;
    clk_n(5);
    rstb = 1'b1;
    clk_n(20);
    start_c();
    send_byte(8'hA0, 1'b0, "t6_adr_ack");
    send_byte(8'h99, 1'b0, "t6_d0_ack");
    send_byte(8'h5A, 1'b0, "t6_d1_ack");
    exp_q.push_back({3'd2, 32'h995A0000});
    stop_c();
    clk_n(20);

    chk("wr_queue_drained", 32'(exp_q.size()), 32'd0);
    chk("rd_req_total", 32'(rd_req_cnt), 32'd2);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
